// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide sequencer.
// Contents:
//   MD_WIDTH       default operand width
//   muldiv_op_e    op encoding driven by the decoder (bit1 = divide, bit0 = signed)
//   muldiv_state_e sequencer FSM states
package muldiv_pkg;
  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULTU = 2'd0,
    MD_MULT  = 2'd1,
    MD_DIVU  = 2'd2,
    MD_DIV   = 2'd3
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIX  = 2'd2,
    MD_DONE = 2'd3
  } muldiv_state_e;
endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration of the sequencer datapath (purely combinational).
// Ports:
//   i_acc  2*WIDTH accumulator (multiply: partial product; divide: {rem, dividend/quotient})
//   i_opd  2*WIDTH operand (multiply: multiplicand already shifted to the current bit;
//          divide: divisor in the low WIDTH bits)
//   i_bit  current multiplier bit (multiply only)
//   i_div  1 = restoring-divide step, 0 = add step
//   o_acc  next accumulator
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [2*WIDTH-1:0] i_opd,
  input  logic               i_bit,
  input  logic               i_div,
  output logic [2*WIDTH-1:0] o_acc
);
  logic [2*WIDTH:0] w_shl;
  logic [WIDTH:0]   w_diff;

  always_comb begin
    w_shl  = {i_acc, 1'b0};
    // Shifted remainder can reach WIDTH+1 bits, so the trial subtract keeps the carry.
    w_diff = w_shl[2*WIDTH:WIDTH] - {1'b0, i_opd[WIDTH-1:0]};
    if (i_div) begin
      o_acc = w_shl[2*WIDTH-1:0];
      if (!w_diff[WIDTH]) begin
        o_acc[2*WIDTH-1:WIDTH] = w_diff[WIDTH-1:0];
        o_acc[0]               = 1'b1;
      end
    end else begin
      o_acc = i_acc + (i_bit ? i_opd : '0);
    end
  end
endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the execute-stage ALU.
// Operands are latched as magnitudes, iterated one bit per cycle, then sign
// corrected in FIX and written to hi/lo.
// Ports:
//   clk, rst_b      clock, async active-low reset
//   start, op, a, b request (accepted when ready and no flush)
//   flush           abort an in-flight op
//   ready, busy     accept / pipeline stall
//   done            one-cycle result pulse
//   hi, lo          product halves or remainder/quotient
//   div_zero        last division had a zero divisor
// Optional: MULDIV_EARLY_OUT_EN ends a multiply as soon as no multiplier
// bits remain.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_zero
);
  localparam int W2 = 2 * WIDTH;

  muldiv_state_e    r_state, w_state_nxt;
  logic [W2-1:0]    r_acc, r_opd, w_step, w_prod;
  logic [WIDTH-1:0] r_mlt, r_hi, r_lo, w_mag_a, w_mag_b, w_quo, w_rem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_div, r_sgn_q, r_sgn_r, r_dz;
  muldiv_op_e       w_op;
  logic             w_is_div, w_is_sgn, w_go, w_dz, w_last;

  assign w_op     = muldiv_op_e'(op);
  assign w_is_div = (w_op == MD_DIVU) || (w_op == MD_DIV);
  assign w_is_sgn = (w_op == MD_MULT) || (w_op == MD_DIV);
  assign w_mag_a  = (w_is_sgn && a[WIDTH-1]) ? -a : a;
  assign w_mag_b  = (w_is_sgn && b[WIDTH-1]) ? -b : b;

  assign ready    = (r_state == MD_IDLE) || (r_state == MD_DONE);
  assign busy     = (r_state == MD_CALC) || (r_state == MD_FIX);
  assign done     = (r_state == MD_DONE);
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign div_zero = r_dz;

  assign w_go     = start && ready && !flush;
  assign w_dz     = w_go && w_is_div && (b == '0);

`ifdef MULDIV_EARLY_OUT_EN
  // Left-shift multiply keeps the product in place, so stopping early needs
  // no realignment once the multiplier bits above the current one are zero.
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1)) || (!r_div && (r_mlt[WIDTH-1:1] == '0));
`else
  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));
`endif

  // Sign fix: product negates as a whole; quotient follows a^b, remainder follows a.
  assign w_prod = r_sgn_q ? -r_acc : r_acc;
  assign w_quo  = r_sgn_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_sgn_r ? -r_acc[W2-1:WIDTH] : r_acc[W2-1:WIDTH];

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_acc (r_acc),
    .i_opd (r_opd),
    .i_bit (r_mlt[0]),
    .i_div (r_div),
    .o_acc (w_step)
  );

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= MD_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      MD_IDLE, MD_DONE: begin
        if (w_go) w_state_nxt = w_dz ? MD_DONE : MD_CALC;
        else      w_state_nxt = MD_IDLE;
      end
      MD_CALC: begin
        if (flush)       w_state_nxt = MD_IDLE;
        else if (w_last) w_state_nxt = MD_FIX;
      end
      MD_FIX:  w_state_nxt = flush ? MD_IDLE : MD_DONE;
      default: w_state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_acc   <= '0;
      r_opd   <= '0;
      r_mlt   <= '0;
      r_cnt   <= '0;
      r_div   <= 1'b0;
      r_sgn_q <= 1'b0;
      r_sgn_r <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_dz    <= 1'b0;
    end else if (w_go) begin
      r_cnt   <= '0;
      r_div   <= w_is_div;
      r_sgn_q <= w_is_sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_sgn_r <= w_is_sgn && a[WIDTH-1];
      r_mlt   <= w_mag_b;
      r_acc   <= w_is_div ? {{WIDTH{1'b0}}, w_mag_a} : '0;
      r_opd   <= {{WIDTH{1'b0}}, (w_is_div ? w_mag_b : w_mag_a)};
      r_dz    <= w_dz;
      if (w_dz) begin
        r_hi <= a;
        r_lo <= '1;
      end
    end else if (!flush) begin
      if (r_state == MD_CALC) begin
        r_acc <= w_step;
        r_cnt <= r_cnt + CNT_W'(1);
        if (!r_div) begin
          r_opd <= r_opd << 1;
          r_mlt <= r_mlt >> 1;
        end
      end else if (r_state == MD_FIX) begin
        if (r_div) begin
          r_hi <= w_rem;
          r_lo <= w_quo;
        end else begin
          r_hi <= w_prod[W2-1:WIDTH];
          r_lo <= w_prod[WIDTH-1:0];
        end
      end
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed vectors push expected hi/lo/
// div_zero/latency; a monitor pops and compares on every done pulse.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0, rst_b = 1'b0, start = 1'b0, flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0, b = '0;
  logic        ready, busy, done, div_zero;
  logic [31:0] hi, lo;

  typedef struct {
    string       nm;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          cyc;
    int          dly;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0, failures = 0;
  int   cyc = 0, n_done = 0, last_done = 0, prev_done = 0, busy_cnt = 0, snap;

  muldiv_seq dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .ready(ready), .busy(busy), .done(done), .hi(hi), .lo(lo), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (busy) busy_cnt++;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Cycles from the accepting edge to the done-cycle sample.
  function automatic int exp_delta(input logic [1:0] o, input logic [31:0] xb);
    logic [31:0] m;
    int h;
    if (o[1] && xb == 32'd0) return 0;
`ifdef MULDIV_EARLY_OUT_EN
    if (!o[1]) begin
      m = (o[0] && xb[31]) ? -xb : xb;
      h = 0;
      for (int i = 0; i < 32; i++) if (m[i]) h = i;
      return h + 2;
    end
`else
    m = xb;
    h = 0;
`endif
    return 33;
  endfunction

  task automatic issue(input string nm, input logic [1:0] o, input logic [31:0] xa,
                       input logic [31:0] xb, input logic [31:0] eh, input logic [31:0] el,
                       input logic ed, input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!ready && n < 200) begin @(negedge clk); n++; end
    if (!ready) begin
      checks++; failures++;
      $display("FAIL %s.ready_timeout actual=%b required=1", nm, ready);
    end
    op = o; a = xa; b = xb; start = 1'b1;
    if (push) begin
      e.nm = nm; e.hi = eh; e.lo = el; e.dz = ed;
      e.cyc = cyc + 1; e.dly = exp_delta(o, xb);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((sb.size() != 0 || !ready) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) begin
      checks++; failures++;
      $display("FAIL %s.done_timeout actual_pending=%0d required=0", nm, sb.size());
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rst_b && done) begin
      n_done++;
      prev_done = last_done;
      last_done = cyc;
      if (sb.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_done actual=1 required=0 hi=%h lo=%h", hi, lo);
      end else begin
        mon_e = sb.pop_front();
        chk({mon_e.nm, ".hi"}, 64'(hi), 64'(mon_e.hi));
        chk({mon_e.nm, ".lo"}, 64'(lo), 64'(mon_e.lo));
        chk({mon_e.nm, ".div_zero"}, 64'(div_zero), 64'(mon_e.dz));
        chk({mon_e.nm, ".latency"}, 64'(cyc - mon_e.cyc), 64'(mon_e.dly));
      end
    end
  end

  initial begin
    #300000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst.ready", 64'(ready), 64'd1);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.hi", 64'(hi), 64'd0);
    chk("rst.lo", 64'(lo), 64'd0);
    chk("rst.div_zero", 64'(div_zero), 64'd0);
    #10 rst_b = 1'b1;

    // Signed multiply, with a stray start while busy that must be ignored.
    issue("mult_7_m3", MD_MULT, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b1);
    busy_cnt = 0;
    start = 1'b1; op = MD_DIVU; a = 32'd1; b = 32'd0;
    @(posedge clk); #1 start = 1'b0;
    wait_idle("mult_7_m3");
    chk("mult_7_m3.busy_cycles", 64'(busy_cnt), 64'(exp_delta(MD_MULT, 32'hFFFF_FFFD)));

    issue("divu_100_7", MD_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1);
    issue("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b1);
    issue("div_7_m2", MD_DIV, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 1'b0, 1'b1);
    issue("mult_min_min", MD_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 1'b0, 1'b1);
    wait_idle("signed_group");

    issue("div_5_0", MD_DIV, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1'b1);
    wait_idle("div_5_0");
    chk("div_5_0.dz_held", 64'(div_zero), 64'd1);
    issue("multu_3_4", MD_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0, 1'b1);
    issue("div_min_m1", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b1);
    wait_idle("div_min_m1");

    // Flush mid-multiply: no done, results untouched.
    snap = n_done;
    issue("flush_op", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush.ready", 64'(ready), 64'd1);
    chk("flush.busy", 64'(busy), 64'd0);
    chk("flush.hi", 64'(hi), 64'd0);
    chk("flush.lo", 64'(lo), 64'h8000_0000);
    chk("flush.div_zero", 64'(div_zero), 64'd0);
    repeat (40) @(negedge clk);
    chk("flush.no_done", 64'(n_done), 64'(snap));

    // Flush with a coincident start in IDLE drops the start.
    start = 1'b1; flush = 1'b1; op = MD_DIVU; a = 32'd5; b = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("flush_start.ready", 64'(ready), 64'd1);
    chk("flush_start.busy", 64'(busy), 64'd0);
    chk("flush_start.done", 64'(done), 64'd0);
    chk("flush_start.div_zero", 64'(div_zero), 64'd0);

    // Back-to-back: second start lands in the DONE cycle of the first.
    issue("b2b_1", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b1);
    issue("b2b_2", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd1, 1'b0, 1'b1);
    wait_idle("b2b");
    chk("b2b.done_spacing", 64'(last_done - prev_done), 64'd34);

    issue("multu_9_1", MD_MULTU, 32'd9, 32'd1, 32'd0, 32'd9, 1'b0, 1'b1);
    wait_idle("multu_9_1");

    // Async reset mid-operation.
    snap = n_done;
    issue("rst_op", MD_MULTU, 32'd123, 32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    chk("arst.ready", 64'(ready), 64'd1);
    chk("arst.busy", 64'(busy), 64'd0);
    chk("arst.hi", 64'(hi), 64'd0);
    chk("arst.lo", 64'(lo), 64'd0);
    @(negedge clk) rst_b = 1'b1;
    repeat (40) @(negedge clk);
    chk("arst.no_done", 64'(n_done), 64'(snap));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
